// File: rtl/data_mem_resp.sv
// ---------------------------------------------------------------------------
// data_mem_resp
//
// Data-memory responder for the RV32I core. It accepts one load/store
// request at a time, holds it for WAIT_STATES cycles, then performs the
// byte/half/word access on an internal word-organised RAM. Completion is
// signalled by a one-cycle rsp_valid pulse carrying extended load data.
//
// Handshake: a request is accepted at a rising edge where
// req_valid && req_ready. req_ready is high only in IDLE. Responses have no
// backpressure: rsp_valid is high for exactly one cycle per accepted request.
//
// Parameters
//   DEPTH_WORDS : RAM depth in 32-bit words (power of two, >= 4)
//   WAIT_STATES : extra cycles between accept and response (0..7)
//
// Optional feature macro: DATA_MEM_MISALIGN_TRAP_EN
//   defined     : misaligned accesses do nothing, respond rdata=0, misaligned=1
//   not defined : misaligned addresses are aligned down, misaligned tied 0
//
// Ports
//   clk, rst_n           : clock (rising edge), async active-low reset
//   req_valid/req_ready  : request handshake
//   mem_read, mem_write  : load / store request
//   func3                : RV32I load/store width code
//   addr, wdata          : byte address, store data
//   rsp_valid            : one-cycle completion pulse
//   rdata                : extended load data, held until the next response
//   misaligned           : misaligned flag, valid with rsp_valid
//   dbg_state            : current FSM state (IDLE=0, WAIT=1, RESP=2)
// ---------------------------------------------------------------------------
module data_mem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic       NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  logic [1:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          rd_q, wr_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          mis_q, mis_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;

  // Operands of the access performed on the edge entering RESP. With no
  // wait states that edge is the accept edge, so the live inputs are used.
  logic          op_rd, op_wr;
  logic [2:0]    op_f3;
  logic [AW+1:0] op_a;
  logic [31:0]   op_wd;

  logic          is_byte, is_half, is_word;
  logic          legal_ld, legal_st;
  logic          do_ld, do_st;
  logic          mis_flag;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic [31:0]   word, shifted, ld_val;
  logic [3:0]    be;
  logic [31:0]   st_data;

  // Upper address bits alias onto the RAM and are intentionally ignored.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  assign accept     = req_valid && req_ready;
  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rdata      = rdata_q;
  assign misaligned = (state_q == S_RESP) && mis_q;
  assign dbg_state  = state_q;

  assign enter_resp = ((state_q == S_IDLE) && accept && NO_WAIT) ||
                      ((state_q == S_WAIT) && (cnt_q == 3'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = NO_WAIT ? S_RESP : S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_rd = (state_q == S_IDLE) ? mem_read  : rd_q;
    op_wr = (state_q == S_IDLE) ? mem_write : wr_q;
    op_f3 = (state_q == S_IDLE) ? func3     : f3_q;
    op_a  = (state_q == S_IDLE) ? addr[AW+1:0] : addr_q;
    op_wd = (state_q == S_IDLE) ? wdata     : wdata_q;
  end

  // Width decode and legality. Stores only have SB/SH/SW; the unsigned
  // codes exist for loads only.
  always_comb begin
    is_byte  = (op_f3[1:0] == 2'b00);
    is_half  = (op_f3[1:0] == 2'b01);
    is_word  = (op_f3 == 3'b010);
    legal_ld = op_rd && !op_wr &&
               (is_byte || is_half || is_word);
    legal_st = op_wr && !op_rd && !op_f3[2] &&
               (is_byte || is_half || is_word);
  end

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  logic mis_raw;
  always_comb begin
    mis_raw  = (legal_ld || legal_st) &&
               ((is_half && op_a[0]) || (is_word && (op_a[1:0] != 2'b00)));
    mis_flag = mis_raw;
    do_ld    = legal_ld && !mis_raw;
    do_st    = legal_st && !mis_raw;
    lane     = op_a[1:0];
  end
`else
  // Misaligned addresses are forced down to the natural alignment.
  always_comb begin
    mis_flag = 1'b0;
    do_ld    = legal_ld;
    do_st    = legal_st;
    if (is_byte)      lane = op_a[1:0];
    else if (is_half) lane = {op_a[1], 1'b0};
    else              lane = 2'b00;
  end
`endif

  always_comb begin
    idx     = op_a[AW+1:2];
    word    = mem[idx];
    shifted = word >> {lane, 3'b000};
    if (is_byte)
      ld_val = {{24{~op_f3[2] & shifted[7]}}, shifted[7:0]};
    else if (is_half)
      ld_val = {{16{~op_f3[2] & shifted[15]}}, shifted[15:0]};
    else
      ld_val = word;

    if (is_byte) begin
      be      = 4'b0001 << lane;
      st_data = {4{op_wd[7:0]}};
    end else if (is_half) begin
      be      = lane[1] ? 4'b1100 : 4'b0011;
      st_data = {2{op_wd[15:0]}};
    end else begin
      be      = 4'b1111;
      st_data = op_wd;
    end
  end

  // Stores, non-load completions and trapped accesses all return zero.
  always_comb begin
    rdata_d = rdata_q;
    mis_d   = mis_q;
    if (enter_resp) begin
      rdata_d = do_ld ? ld_val : 32'd0;
      mis_d   = mis_flag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      if (accept) begin
        rd_q    <= mem_read;
        wr_q    <= mem_write;
        f3_q    <= func3;
        addr_q  <= addr[AW+1:0];
        wdata_q <= wdata;
      end
    end
  end

  // RAM is not reset. The rst_n gate keeps a request seen during reset
  // from writing.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && do_st) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

  localparam int DEPTH = 256;
  localparam int WS    = 1;
  localparam int NBYTE = DEPTH * 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        misaligned;
  logic [1:0]  dbg_state;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic        exp_mis_q[$];

  // Reference memory kept as a flat byte array in little-endian order.
  logic [7:0] mb [NBYTE];

  data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .func3(func3), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rdata(rdata), .misaligned(misaligned),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] er, output logic em);
    int ea, size;
    logic ld_ok, st_ok, mis;
    logic [31:0] v, mask;
    er = 32'd0;
    em = 1'b0;
    ld_ok = rd && !wr && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    st_ok = wr && !rd && (f3 inside {3'd0, 3'd1, 3'd2});
    if (!(ld_ok || st_ok)) return;
    size = 1 << f3[1:0];
    ea   = int'(a % NBYTE);
    mis  = (ea % size) != 0;
    if (mis) begin
`ifdef DATA_MEM_MISALIGN_TRAP_EN
      em = 1'b1;
      return;
`else
      ea = ea - (ea % size);
`endif
    end
    if (st_ok) begin
      for (int i = 0; i < size; i++) mb[ea + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(mb[ea + i]) << (8 * i));
      if (size < 4 && !f3[2]) begin
        mask = (32'd1 << (8 * size)) - 32'd1;
        if (v[8*size-1]) v = v | ~mask;
      end
      er = v;
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge with the
  // DUT idle again. While busy, a garbage store is held on the request
  // lines to show that requests are ignored when not ready.
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic chk_data, output logic [31:0] got);
    logic [31:0] er, e;
    logic em, e_mis;
    int lat;
    model(rd, wr, f3, a, wd, er, em);
    exp_q.push_back(er);
    exp_mis_q.push_back(em);
    check_eq("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    mem_read  = rd;
    mem_write = wr;
    func3     = f3;
    addr      = a;
    wdata     = wd;
    @(posedge clk);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b1;
    func3     = 3'b010;
    addr      = $urandom;
    wdata     = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      check_eq("ready_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(WS + 1));
    check_eq("ready_resp", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    e     = exp_q.pop_front();
    e_mis = exp_mis_q.pop_front();
    got   = rdata;
    if (chk_data) check_eq("rdata", rdata, e);
    check_eq("misaligned", 32'(misaligned), 32'(e_mis));
    @(negedge clk);
    check_eq("rsp_pulse", 32'(rsp_valid), 32'd0);
    check_eq("ready_idle", 32'(req_ready), 32'd1);
    check_eq("rdata_hold", rdata, got);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] got, old10;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    func3     = 3'd0;
    addr      = 32'd0;
    wdata     = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_misaligned", 32'(misaligned), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill the RAM so every later load has a known reference value.
    for (int i = 0; i < DEPTH; i++) do_req(1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom, 1'b0, got);

    // Reset mid-WAIT drops a pending store.
    do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 1'b1, old10);
    req_valid = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b1;
    func3     = 3'b010;
    addr      = 32'h10;
    wdata     = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rstw_ready", 32'(req_ready), 32'd1);
    check_eq("rstw_rdata", rdata, 32'd0);
    check_eq("rstw_misaligned", 32'(misaligned), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rstw_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstw_no_rsp_after", 32'(rsp_valid), 32'd0);
    do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 1'b1, got);
    check_eq("rstw_old_value", got, old10);

    // Latency and read-after-write.
    do_req(1'b0, 1'b1, 3'b010, 32'h20, 32'h12345678, 1'b0, got);
    do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 1'b1, got);
    check_eq("raw_20", got, 32'h12345678);

    // Byte lanes.
    do_req(1'b0, 1'b1, 3'b010, 32'h40, 32'h12345678, 1'b0, got);
    do_req(1'b0, 1'b1, 3'b000, 32'h41, 32'h555555AB, 1'b0, got);
    do_req(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 1'b1, got);
    check_eq("lw_after_sb", got, 32'h1234AB78);
    do_req(1'b1, 1'b0, 3'b000, 32'h41, 32'd0, 1'b1, got);
    check_eq("lb_41", got, 32'hFFFFFFAB);
    do_req(1'b1, 1'b0, 3'b100, 32'h41, 32'd0, 1'b1, got);
    check_eq("lbu_41", got, 32'h000000AB);
    do_req(1'b1, 1'b0, 3'b001, 32'h42, 32'd0, 1'b1, got);
    check_eq("lh_42", got, 32'h00001234);

    // Aliasing wrap.
    do_req(1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 1'b0, got);
    do_req(1'b1, 1'b0, 3'b010, 32'h0, 32'd0, 1'b1, got);
    check_eq("wrap_0", got, 32'hCAFEF00D);

    // No-op completions.
    do_req(1'b1, 1'b1, 3'b010, 32'h0, 32'h11111111, 1'b1, got);
    check_eq("nop_both", got, 32'd0);
    do_req(1'b0, 1'b1, 3'b011, 32'h0, 32'h22222222, 1'b1, got);
    do_req(1'b1, 1'b0, 3'b011, 32'h0, 32'd0, 1'b1, got);
    check_eq("nop_f3_011", got, 32'd0);
    do_req(1'b0, 1'b0, 3'b010, 32'h0, 32'h33333333, 1'b1, got);
    do_req(1'b1, 1'b0, 3'b010, 32'h0, 32'd0, 1'b1, got);
    check_eq("nop_ram_kept", got, 32'hCAFEF00D);

    // Misaligned word load.
    do_req(1'b1, 1'b0, 3'b010, 32'h42, 32'd0, 1'b1, got);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    check_eq("mis_lw_42", got, 32'd0);
`else
    check_eq("mis_lw_42", got, 32'h1234AB78);
`endif
    do_req(1'b0, 1'b1, 3'b001, 32'h43, 32'h0000BEEF, 1'b0, got);
    do_req(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 1'b1, got);

    // Randomized traffic against the byte-array model.
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic rd, wr;
      logic [2:0] f3;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      rd = (kind <= 3) || (kind == 8);
      wr = (kind >= 4 && kind <= 8);
      case ($urandom_range(0, 7))
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd2;
        3: f3 = 3'd4;
        4: f3 = 3'd5;
        5: f3 = 3'd2;
        6: f3 = 3'd1;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      do_req(rd, wr, f3, a, $urandom, !(wr && !rd), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
